// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell processes a-b LSB first,
// one bit per clock, and presents diff/borrow with a single-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;
  logic             d_bit;
  logic             bout_bit;

  // Single full-subtractor cell on the current LSBs and the running borrow.
  assign d_bit    = a_sh_reg[0] ^ b_sh_reg[0] ^ borrow_reg;
  assign bout_bit = (~a_sh_reg[0] & b_sh_reg[0]) |
                    (~(a_sh_reg[0] ^ b_sh_reg[0]) & borrow_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (cnt_reg == CW'(1)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == ST_SHIFT);
    done = (state_reg == ST_DONE);
  end

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            borrow_reg <= 1'b0;
            cnt_reg    <= CW'(WIDTH);
          end
        end
        ST_SHIFT: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          diff_reg   <= {d_bit, diff_reg[WIDTH-1:1]};
          borrow_reg <= bout_bit;
          cnt_reg    <= cnt_reg - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign diff   = diff_reg;
  assign borrow = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus queues hand-computed results,
// a negedge monitor checks them (and their timing) whenever done is seen.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;
  logic             done;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   busy_run = 0;
  bit   abort = 1'b0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .diff   (diff),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops an expected result on every done pulse and checks value and latency.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending operation", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (diff !== e.diff || borrow !== e.borrow) begin
          n_fail++;
          $display("FAIL result: diff=%02h borrow=%0b, required diff=%02h borrow=%0b",
                   diff, borrow, e.diff, e.borrow);
        end else begin
          $display("vector ok: diff=%02h borrow=%0b at cycle %0d", diff, borrow, cyc);
        end
        n_vec++;
        if (cyc != e.cyc + WIDTH) begin
          n_fail++;
          $display("FAIL done_latency: done at cycle %0d, required %0d", cyc, e.cyc + WIDTH);
        end
      end
      n_vec++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_in_done: busy=%b, required 0", busy);
      end
    end
    if (busy === 1'b1) begin
      busy_run++;
      if (rst === 1'b1) abort = 1'b1;
    end else if (busy_run != 0) begin
      if (!abort) begin
        n_vec++;
        if (busy_run != WIDTH) begin
          n_fail++;
          $display("FAIL busy_length: busy for %0d cycles, required %0d", busy_run, WIDTH);
        end
      end
      busy_run = 0;
      abort = 1'b0;
    end
  end

  task automatic push_exp(input logic [WIDTH-1:0] d, input logic bo);
    exp_t e;
    e.diff = d;
    e.borrow = bo;
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic check_hold(input string name, input logic [WIDTH-1:0] d, input logic bo);
    n_vec++;
    if (diff !== d || borrow !== bo) begin
      n_fail++;
      $display("FAIL %s: diff=%02h borrow=%0b, required diff=%02h borrow=%0b",
               name, diff, borrow, d, bo);
    end
  endtask

  // Entered just after an edge; returns just after the edge that re-enters IDLE.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH-1:0] d, input logic bo);
    start = 1'b1;
    a = av;
    b = bv;
    @(posedge clk); #1;
    push_exp(d, bo);
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    repeat (WIDTH + 1) @(posedge clk);
    #1;
    check_hold("hold_after_done", d, bo);
  endtask

  initial begin
    logic [WIDTH-1:0] va [3];
    logic [WIDTH-1:0] vb [3];
    logic [WIDTH-1:0] vd [3];
    logic             vbo [3];

    rst = 1'b1;
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (diff !== 8'h00 || borrow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: diff=%02h borrow=%b busy=%b done=%b, required all 0",
               diff, borrow, busy, done);
    end
    rst = 1'b0;

    // First start coincides with the first edge that has rst low.
    run_op(8'd200, 8'd55, 8'h91, 1'b0);
    run_op(8'd5,   8'd10, 8'hFB, 1'b1);
    run_op(8'h00,  8'h01, 8'hFF, 1'b1);
    run_op(8'h00,  8'h00, 8'h00, 1'b0);
    run_op(8'hFF,  8'h00, 8'hFF, 1'b0);
    run_op(8'hFF,  8'hFF, 8'h00, 1'b0);
    run_op(8'h80,  8'h7F, 8'h01, 1'b0);
    run_op(8'h7F,  8'h80, 8'hFF, 1'b1);

    // Start pulsed mid-operation must be ignored.
    start = 1'b1;
    a = 8'h3C;
    b = 8'h50;
    @(posedge clk); #1;
    push_exp(8'hEC, 1'b1);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);
    #1;
    check_hold("ignored_start_hold", 8'hEC, 1'b1);

    // Reset on the fourth SHIFT edge aborts the operation without a done pulse.
    start = 1'b1;
    a = 8'h33;
    b = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (diff !== 8'h00 || borrow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_shift_reset: diff=%02h borrow=%b busy=%b done=%b, required all 0",
               diff, borrow, busy, done);
    end
    repeat (WIDTH + 4) @(posedge clk);
    #1;
    run_op(8'd100, 8'd1, 8'd99, 1'b0);

    // Start held high: a new operation every WIDTH+2 cycles.
    va[0] = 8'h12; vb[0] = 8'h34; vd[0] = 8'hDE; vbo[0] = 1'b1;
    va[1] = 8'hA5; vb[1] = 8'h5A; vd[1] = 8'h4B; vbo[1] = 1'b0;
    va[2] = 8'h01; vb[2] = 8'hFF; vd[2] = 8'h02; vbo[2] = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 3 * (WIDTH + 2); c++) begin
      if (c % (WIDTH + 2) == 0) begin
        a = va[c / (WIDTH + 2)];
        b = vb[c / (WIDTH + 2)];
      end else begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
      end
      @(posedge clk); #1;
      if (c % (WIDTH + 2) == 0) push_exp(vd[c / (WIDTH + 2)], vbo[c / (WIDTH + 2)]);
    end
    start = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);
    #1;

    n_vec++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_results: %0d results never produced, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepted start.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepted start.
REQ-007 diff  output  WIDTH  result a-b mod 2^WIDTH; registered.
REQ-008 borrow  output  1  final borrow; 1 when a < b (unsigned); registered.
REQ-009 busy  output  1  high while an operation is in progress (SHIFT state).
REQ-010 done  output  1  one-cycle pulse when diff/borrow become valid.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE, with no other reachable states.
REQ-012 IDLE -> SHIFT on a rising edge with start=1: capture a and b into shift registers, clear the borrow flop to 0, load the bit counter with WIDTH.
REQ-013 In SHIFT, each edge processes one bit, LSB first, through a single full-subtractor cell (d = ai^bi^bin; bout = (~ai&bi) | (~(ai^bi)&bin)).
REQ-014 In SHIFT, d SHALL shift into the diff register MSB, bout SHALL register into the borrow flop, and the a/b registers SHALL shift right by one.
REQ-015 SHIFT -> DONE on the edge processing the final bit (bit counter reaches 0); exactly WIDTH edges in SHIFT.
REQ-016 DONE -> IDLE unconditionally on the next edge.
REQ-017 Latency: start accepted at edge k; done=1 during the cycle after edge k+WIDTH; back in IDLE after edge k+WIDTH+1.
REQ-018 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE.
REQ-019 diff and borrow SHALL hold the last completed result from DONE until the next accepted start.
REQ-020 diff and borrow contents during SHIFT are intermediate and carry no meaning.
REQ-021 start in SHIFT or DONE SHALL be ignored (no queuing); a and b changes outside the accept edge SHALL have no effect.
REQ-022 Maximum throughput is one operation per WIDTH+2 cycles; start held high continuously SHALL re-trigger from each IDLE.
REQ-023 Wrap-around: a < b SHALL yield diff = 2^WIDTH + a - b and borrow=1; a >= b SHALL yield borrow=0.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and set diff=0, borrow=0, busy=0, done=0, and the internal shift registers and counter to 0.
REQ-025 rst SHALL take priority over start and over any in-progress operation; a reset mid-SHIFT aborts without a done pulse.
REQ-026 The first start SHALL be accepted on the first edge with rst=0 and start=1.

Verification
REQ-027 WIDTH=8, a=200, b=55, start one cycle -> busy for 8 cycles; then done one cycle with diff=145 (0x91), borrow=0.
REQ-028 a=5, b=10 -> diff=0xFB, borrow=1.
REQ-029 a=0x00, b=0x01 -> diff=0xFF, borrow=1; then a=0, b=0 -> diff=0x00, borrow=0.
REQ-030 Pulse start again 3 cycles into SHIFT with a=0xFF, b=0x00 -> ignored; the original result is produced and done pulses only once.
REQ-031 Assert rst at SHIFT cycle 4 -> next cycle all outputs 0 and FSM in IDLE, with no done pulse; a new start with a=100, b=1 -> diff=99, borrow=0.
REQ-032 Hold start high for 30 cycles with random a/b -> successive results match a-b mod 256, spaced 10 cycles apart.
